// File: rtl/decode_stage.sv
// RV32I decode stage: decodes if_instr, reads regfile operands and registers them into execute.
// Latency: 1 cycle from accept (if_valid & if_ready) to ex_valid.
// Backpressure: if_ready drops on load-use/memory hazards or a held execute register; flush overrides.
//
// Ports:
//   clk, reset_n             clock, synchronous active-low reset
//   if_valid/if_ready        fetch handshake carrying if_pc, if_instr
//   rs1_sel/rs2_sel          combinational regfile read selects; rs1_data/rs2_data same-cycle data
//   byp_valid/byp_rd/byp_data memory-stage result for hazard detection (and bypass when enabled)
//   flush                    kills execute register and consumes/drops the offered instruction
//   ex_valid/ex_ready        execute handshake carrying ex_pc, ex_instr, ex_rs1_val, ex_rs2_val,
//                            ex_imm, ex_rd, ex_is_load, ex_illegal
// Build option: define DECODE_BYPASS_EN to forward byp_data instead of stalling on memory hazards.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  output logic [4:0]  rs1_sel,
  output logic [4:0]  rs2_sel,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        byp_valid,
  input  logic [4:0]  byp_rd,
  input  logic [31:0] byp_data,
  input  logic        flush,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_instr,
  output logic [31:0] ex_rs1_val,
  output logic [31:0] ex_rs2_val,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_is_load,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic        ex_valid_q, ex_valid_d;
  logic [31:0] ex_pc_q, ex_pc_d, ex_instr_q, ex_instr_d;
  logic [31:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_imm_q, ex_imm_d;
  logic [4:0]  ex_rd_q, ex_rd_d;
  logic        ex_is_load_q, ex_is_load_d, ex_illegal_q, ex_illegal_d;

  logic        use1, use2, wr_rd, is_load, illegal;
  logic [31:0] imm;
  logic        load_use, byp_hit1, byp_hit2, mem_haz, stall, transfer;
  logic [31:0] op1, op2;

  assign rs1_sel = if_instr[19:15];
  assign rs2_sel = if_instr[24:20];

  always_comb begin
    use1    = 1'b0;
    use2    = 1'b0;
    wr_rd   = 1'b0;
    is_load = 1'b0;
    illegal = 1'b0;
    imm     = 32'h0;
    case (if_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        wr_rd = 1'b1;
        imm   = {if_instr[31:12], 12'h000};
      end
      OPC_JAL: begin
        wr_rd = 1'b1;
        imm   = {{12{if_instr[31]}}, if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        use1  = 1'b1;
        wr_rd = 1'b1;
        imm   = {{21{if_instr[31]}}, if_instr[30:20]};
      end
      OPC_BRANCH: begin
        use1 = 1'b1;
        use2 = 1'b1;
        imm  = {{20{if_instr[31]}}, if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
      end
      OPC_LOAD: begin
        use1    = 1'b1;
        wr_rd   = 1'b1;
        is_load = 1'b1;
        imm     = {{21{if_instr[31]}}, if_instr[30:20]};
      end
      OPC_STORE: begin
        use1 = 1'b1;
        use2 = 1'b1;
        imm  = {{21{if_instr[31]}}, if_instr[30:25], if_instr[11:7]};
      end
      OPC_OPIMM: begin
        use1  = 1'b1;
        wr_rd = 1'b1;
        imm   = {{21{if_instr[31]}}, if_instr[30:20]};
      end
      OPC_OP: begin
        use1  = 1'b1;
        use2  = 1'b1;
        wr_rd = 1'b1;
      end
      // FENCE/ECALL/EBREAK: no register traffic, I-format immediate kept for execute.
      OPC_FENCE, OPC_SYSTEM: imm = {{21{if_instr[31]}}, if_instr[30:20]};
      default: illegal = 1'b1;
    endcase
  end

  // ex_rd_q is never nonzero for x0, so a match implies a nonzero source.
  assign load_use = ex_valid_q & ex_is_load_q & (ex_rd_q != 5'd0) &
                    ((use1 & (rs1_sel == ex_rd_q)) | (use2 & (rs2_sel == ex_rd_q)));
  assign byp_hit1 = byp_valid & (byp_rd != 5'd0) & use1 & (byp_rd == rs1_sel);
  assign byp_hit2 = byp_valid & (byp_rd != 5'd0) & use2 & (byp_rd == rs2_sel);
  assign mem_haz  = byp_hit1 | byp_hit2;

`ifdef DECODE_BYPASS_EN
  // Memory-stage result is younger than WB data arriving through the regfile.
  assign stall = load_use;
  assign op1   = byp_hit1 ? byp_data : rs1_data;
  assign op2   = byp_hit2 ? byp_data : rs2_data;
`else
  logic unused_byp;
  assign unused_byp = ^byp_data;
  assign stall = load_use | mem_haz;
  assign op1   = rs1_data;
  assign op2   = rs2_data;
`endif

  assign if_ready = reset_n & (flush | (~stall & (~ex_valid_q | ex_ready)));
  assign transfer = if_valid & if_ready & ~flush;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_instr_d   = ex_instr_q;
    ex_rs1_d     = ex_rs1_q;
    ex_rs2_d     = ex_rs2_q;
    ex_imm_d     = ex_imm_q;
    ex_rd_d      = ex_rd_q;
    ex_is_load_d = ex_is_load_q;
    ex_illegal_d = ex_illegal_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (transfer) begin
      ex_valid_d   = 1'b1;
      ex_pc_d      = if_pc;
      ex_instr_d   = if_instr;
      ex_rs1_d     = op1;
      ex_rs2_d     = op2;
      ex_imm_d     = imm;
      ex_rd_d      = wr_rd ? if_instr[11:7] : 5'd0;
      ex_is_load_d = is_load;
      ex_illegal_d = illegal;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= 32'h0;
      ex_instr_q   <= NOP_INSTR;
      ex_rs1_q     <= 32'h0;
      ex_rs2_q     <= 32'h0;
      ex_imm_q     <= 32'h0;
      ex_rd_q      <= 5'd0;
      ex_is_load_q <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_instr_q   <= ex_instr_d;
      ex_rs1_q     <= ex_rs1_d;
      ex_rs2_q     <= ex_rs2_d;
      ex_imm_q     <= ex_imm_d;
      ex_rd_q      <= ex_rd_d;
      ex_is_load_q <= ex_is_load_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_instr   = ex_instr_q;
  assign ex_rs1_val = ex_rs1_q;
  assign ex_rs2_val = ex_rs2_q;
  assign ex_imm     = ex_imm_q;
  assign ex_rd      = ex_rd_q;
  assign ex_is_load = ex_is_load_q;
  assign ex_illegal = ex_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed instruction stream with an expected-result queue.
// Latency: expected entries pushed on accept, popped when execute consumes.
// Backpressure: exercises load-use, memory-hazard, held-execute and flush cases.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n, if_valid, if_ready, byp_valid, flush, ex_valid, ex_ready;
  logic [31:0] if_pc, if_instr, rs1_data, rs2_data, byp_data;
  logic [31:0] ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  rs1_sel, rs2_sel, byp_rd, ex_rd;
  logic        ex_is_load, ex_illegal;

  typedef struct packed {
    logic [31:0] pc, instr, r1, r2, imm;
    logic [4:0]  rd;
    logic        ld, ill;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .byp_valid(byp_valid), .byp_rd(byp_rd),
    .byp_data(byp_data), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_instr(ex_instr), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
  );

  // Regfile model: xN reads 0x1000+N, x0 reads 0.
  function automatic logic [31:0] rfv(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : (32'h1000 | {27'h0, r});
  endfunction

  assign rs1_data = rfv(rs1_sel);
  assign rs2_data = rfv(rs2_sel);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] r1,
                      input logic [31:0] r2, input logic [31:0] imm, input logic [4:0] rd,
                      input logic ld, input logic ill);
    exp_t e;
    e.pc = pc; e.instr = instr; e.r1 = r1; e.r2 = r2; e.imm = imm;
    e.rd = rd; e.ld = ld; e.ill = ill;
    exp_q.push_back(e);
  endtask

  // Consume check happens with inputs settled, before the edge; then advance one cycle.
  task automatic tick();
    exp_t e;
    if (ex_valid && ex_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_issue", {ex_pc}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_instr", ex_instr, e.instr);
        chk("ex_rs1_val", ex_rs1_val, e.r1);
        chk("ex_rs2_val", ex_rs2_val, e.r2);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_rd", {27'h0, ex_rd}, {27'h0, e.rd});
        chk("ex_is_load", {31'h0, ex_is_load}, {31'h0, e.ld});
        chk("ex_illegal", {31'h0, ex_illegal}, {31'h0, e.ill});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr);
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    #1;
  endtask

  initial begin
    reset_n = 1'b0; if_valid = 1'b1; if_pc = 32'h0; if_instr = 32'h00500093;
    byp_valid = 1'b0; byp_rd = 5'd0; byp_data = 32'h0; flush = 1'b0; ex_ready = 1'b1;

    // Reset: two cycles with fetch offering.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_ex_valid", {31'h0, ex_valid}, 32'h0);
    chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
    chk("rst_ex_instr", ex_instr, 32'h00000013);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_ex_rd", {27'h0, ex_rd}, 32'h0);
    chk("rst_ex_illegal", {31'h0, ex_illegal}, 32'h0);
    reset_n = 1'b1;

    // addi x1,x0,5
    offer(32'h100, 32'h00500093);
    chk("rs1_sel", {27'h0, rs1_sel}, 32'd0);
    chk("rs2_sel", {27'h0, rs2_sel}, 32'd5);
    chk("addi_if_ready", {31'h0, if_ready}, 32'h1);
    push(32'h100, 32'h00500093, 32'h0, 32'h1005, 32'd5, 5'd1, 1'b0, 1'b0);
    tick();
    chk("addi_ex_valid", {31'h0, ex_valid}, 32'h1);
    chk("addi_ex_rd", {27'h0, ex_rd}, 32'd1);
    chk("addi_ex_imm", ex_imm, 32'd5);

    // lw x2,0(x1) then add x3,x2,x2: one bubble
    offer(32'h104, 32'h0000A103);
    chk("lw_if_ready", {31'h0, if_ready}, 32'h1);
    push(32'h104, 32'h0000A103, 32'h1001, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0);
    tick();
    offer(32'h108, 32'h002101B3);
    chk("lu_if_ready", {31'h0, if_ready}, 32'h0);
    tick();
    chk("lu_bubble", {31'h0, ex_valid}, 32'h0);
    chk("lu_if_ready_after", {31'h0, if_ready}, 32'h1);
    push(32'h108, 32'h002101B3, 32'h1002, 32'h1002, 32'h0, 5'd3, 1'b0, 1'b0);
    tick();
    chk("add_ex_valid", {31'h0, ex_valid}, 32'h1);

    // Memory-stage hazard: add x4,x3,x0 with x3 pending in memory
    byp_valid = 1'b1; byp_rd = 5'd3; byp_data = 32'h0000CAFE;
    offer(32'h10C, 32'h00018233);
`ifdef DECODE_BYPASS_EN
    chk("byp_if_ready", {31'h0, if_ready}, 32'h1);
    push(32'h10C, 32'h00018233, 32'h0000CAFE, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0);
    tick();
    byp_valid = 1'b0;
`else
    chk("mh_if_ready0", {31'h0, if_ready}, 32'h0);
    tick();
    chk("mh_if_ready1", {31'h0, if_ready}, 32'h0);
    chk("mh_bubble", {31'h0, ex_valid}, 32'h0);
    tick();
    chk("mh_if_ready2", {31'h0, if_ready}, 32'h0);
    byp_valid = 1'b0;
    #1;
    chk("mh_release", {31'h0, if_ready}, 32'h1);
    push(32'h10C, 32'h00018233, 32'h1003, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0);
    tick();
`endif

    // Execute holds for 3 cycles, then flush drops everything
    ex_ready = 1'b0;
    offer(32'h110, 32'h00700293);
    chk("hold_if_ready", {31'h0, if_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_ex_valid", {31'h0, ex_valid}, 32'h1);
      chk("hold_ex_pc", ex_pc, 32'h10C);
      chk("hold_ex_instr", ex_instr, 32'h00018233);
      chk("hold_if_ready", {31'h0, if_ready}, 32'h0);
    end
    flush = 1'b1;
    #1;
    chk("flush_if_ready", {31'h0, if_ready}, 32'h1);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    exp_q.delete();
    chk("flush_ex_valid", {31'h0, ex_valid}, 32'h0);
    ex_ready = 1'b1;
    tick();
    chk("flush_dropped", {31'h0, ex_valid}, 32'h0);

    // Illegal opcode with nonzero rd field, then each immediate format
    offer(32'h114, 32'h00000FFF);
    chk("ill_if_ready", {31'h0, if_ready}, 32'h1);
    push(32'h114, 32'h00000FFF, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    tick();
    chk("ill_ex_illegal", {31'h0, ex_illegal}, 32'h1);
    chk("ill_ex_rd", {27'h0, ex_rd}, 32'h0);
    offer(32'h118, 32'hFE20AE23);   // sw x2,-4(x1)
    chk("sw_if_ready", {31'h0, if_ready}, 32'h1);
    push(32'h118, 32'hFE20AE23, 32'h1001, 32'h1002, 32'hFFFFFFFC, 5'd0, 1'b0, 1'b0);
    tick();
    offer(32'h11C, 32'h123453B7);   // lui x7,0x12345
    chk("lui_if_ready", {31'h0, if_ready}, 32'h1);
    push(32'h11C, 32'h123453B7, rfv(5'd8), rfv(5'd3), 32'h12345000, 5'd7, 1'b0, 1'b0);
    tick();
    offer(32'h120, 32'h008000EF);   // jal x1,8
    chk("jal_if_ready", {31'h0, if_ready}, 32'h1);
    push(32'h120, 32'h008000EF, rfv(5'd0), rfv(5'd8), 32'd8, 5'd1, 1'b0, 1'b0);
    tick();
    offer(32'h124, 32'hFE208CE3);   // beq x1,x2,-8
    chk("beq_if_ready", {31'h0, if_ready}, 32'h1);
    push(32'h124, 32'hFE208CE3, 32'h1001, 32'h1002, 32'hFFFFFFF8, 5'd0, 1'b0, 1'b0);
    tick();
    if_valid = 1'b0;
    tick();
    tick();
    chk("sb_left", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
